// File: rtl/alu32_pkg.sv
// Shared opcode, width and state definitions for the 32-bit ALU request controller.
package alu32_pkg;

  localparam int OP_W = 3;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu32_req_ctrl.sv
// Requester/sequencer for the external 32-bit ALU: operand issue, fixed-latency wait, response return.
// Optional macro ALU_REQ_STATS_EN adds a saturating ops_done response counter.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// WAIT  | operands on the ALU, counting down the ALU latency
// RESP  | rsp_valid=1, holding the result until rsp_ready
module alu32_req_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int OP_W    = alu32_pkg::OP_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  output logic [31:0]     alu_in1,
  output logic [31:0]     alu_in2,
  output logic [OP_W-1:0] alu_op,
  input  logic [31:0]     alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic            rsp_zero,
  output logic            rsp_err
`ifdef ALU_REQ_STATS_EN
  ,
  output logic [15:0]     ops_done
`endif
);
  import alu32_pkg::*;

  generate
    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_bad_lat
      $error("alu32_req_ctrl: ALU_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept, capture, rsp_done, rsvd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_ready && req_valid) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd1)            state_nxt = RESP;
      RESP:    if (rsp_ready)              state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == IDLE) && req_ready && req_valid;
    capture  = (state == WAIT) && (cnt == 4'd1);
    rsp_done = (state == RESP) && rsp_ready;
    rsvd     = (alu_op == OP_W'(OP_RSVD));
  end

  // req_ready is simply "next state is IDLE", which also gives the one-edge delay out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      if (accept) begin
        alu_in1 <= req_a;
        alu_in2 <= req_b;
        alu_op  <= req_op;
        cnt     <= LAT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= rsvd ? 32'h0 : alu_out;
        rsp_zero   <= rsvd || (alu_out == 32'h0);
        rsp_err    <= rsvd;
      end else if (rsp_done) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_REQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                ops_done <= '0;
    else if (rsp_done && ops_done != 16'hFFFF) ops_done <= ops_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu32_req_ctrl.sv
// Self-checking bench: two controllers (ALU_LAT=1 and 3) driven by directed and random requests.
module tb_alu32_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [2:0]  req_op     [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic [31:0] alu_in1    [2];
  logic [31:0] alu_in2    [2];
  logic [2:0]  alu_op     [2];
  logic [31:0] alu_out    [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic        rsp_zero   [2];
  logic        rsp_err    [2];
`ifdef ALU_REQ_STATS_EN
  logic [15:0] ops_done   [2];
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_done [2];

  always #5 clk = ~clk;

  // Stand-in for the external gate slices and result mux; the reserved code returns junk on purpose.
  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return ~(a | b);
      3'b011:  return a ^ b;
      3'b100:  return a + b;
      3'b101:  return a - b;
      3'b110:  return {31'b0, $signed(a) < $signed(b)};
      default: return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 3'b111) return 32'h0;
    return alu_model(op, a, b);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign alu_out[g] = alu_model(alu_op[g], alu_in1[g], alu_in2[g]);
    alu32_req_ctrl #(.ALU_LAT((g == 0) ? 1 : 3), .OP_W(3)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_op     (req_op[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .alu_in1    (alu_in1[g]),
      .alu_in2    (alu_in2[g]),
      .alu_op     (alu_op[g]),
      .alu_out    (alu_out[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_result (rsp_result[g]),
      .rsp_zero   (rsp_zero[g]),
      .rsp_err    (rsp_err[g])
`ifdef ALU_REQ_STATS_EN
      ,
      .ops_done   (ops_done[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_all_zero(input int k, input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready[k]), 32'h0);
    chk({tag, "_alu_in1"},   alu_in1[k],        32'h0);
    chk({tag, "_alu_in2"},   alu_in2[k],        32'h0);
    chk({tag, "_alu_op"},    32'(alu_op[k]),    32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid[k]), 32'h0);
    chk({tag, "_rsp_result"}, rsp_result[k],    32'h0);
    chk({tag, "_rsp_zero"},  32'(rsp_zero[k]),  32'h0);
    chk({tag, "_rsp_err"},   32'(rsp_err[k]),   32'h0);
`ifdef ALU_REQ_STATS_EN
    chk({tag, "_ops_done"},  32'(ops_done[k]),  32'h0);
`endif
  endtask

  // Issue one request, check latency, result and flags, optionally stall the response with an intruding request.
  task automatic do_op(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    int n;
    logic [31:0] er;
    er = ref_result(op, a, b);
    n = 0;
    while (!req_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[k]) begin chk("req_ready_timeout", 32'(req_ready[k]), 32'h1); return; end
    req_valid[k] = 1'b1; req_op[k] = op; req_a[k] = a; req_b[k] = b;
    rsp_ready[k] = (stall == 0);
    @(negedge clk);
    req_valid[k] = 1'b0; req_a[k] = $urandom; req_b[k] = $urandom;
    chk("accept_req_ready", 32'(req_ready[k]), 32'h0);
    chk("accept_alu_op", 32'(alu_op[k]), 32'(op));
    n = 0;
    while (!rsp_valid[k] && n < 40) begin
      chk("wait_alu_in1", alu_in1[k], a);
      chk("wait_alu_in2", alu_in2[k], b);
      @(negedge clk); n++;
    end
    chk("latency", n, lat_of(k));
    if (!rsp_valid[k]) return;
    chk("rsp_result", rsp_result[k], er);
    chk("rsp_zero", 32'(rsp_zero[k]), 32'(er == 32'h0));
    chk("rsp_err", 32'(rsp_err[k]), 32'(op == 3'b111));
    for (int i = 0; i < stall; i++) begin
      req_valid[k] = 1'b1; req_op[k] = op ^ 3'b001; req_a[k] = ~a; req_b[k] = ~b;
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid[k]), 32'h1);
      chk("stall_rsp_result", rsp_result[k], er);
      chk("stall_rsp_zero", 32'(rsp_zero[k]), 32'(er == 32'h0));
      chk("stall_no_accept_in1", alu_in1[k], a);
      chk("stall_req_ready", 32'(req_ready[k]), 32'h0);
    end
    req_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    if (exp_done[k] < 16'hFFFF) exp_done[k]++;
    chk("done_rsp_valid", 32'(rsp_valid[k]), 32'h0);
    chk("done_req_ready", 32'(req_ready[k]), 32'h1);
    chk("done_alu_in1_held", alu_in1[k], a);
`ifdef ALU_REQ_STATS_EN
    chk("ops_done", 32'(ops_done[k]), 32'(exp_done[k]));
`endif
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          k;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = '0; req_a[i] = '0; req_b[i] = '0;
      rsp_ready[i] = 1'b0; exp_done[i] = 0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) chk_all_zero(i, "reset");
    rst = 1'b0;
    #1;
    chk("release_req_ready_before_edge", 32'(req_ready[0]), 32'h0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("release_req_ready", 32'(req_ready[i]), 32'h1);
      chk("release_rsp_valid", 32'(rsp_valid[i]), 32'h0);
    end

    do_op(0, 3'b010, 32'h0000_FFFF, 32'h00FF_00FF, 0);
    do_op(0, 3'b000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5);
    do_op(0, 3'b001, 32'h0F0F_F0F0, 32'hF0F0_0F0F, 0);
    do_op(1, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(1, 3'b111, 32'h1234_5678, 32'h0000_0000, 2);
    do_op(1, 3'b110, 32'h8000_0000, 32'h0000_0001, 0);

    // Reset pulsed one cycle into WAIT on the ALU_LAT=3 controller
    req_valid[1] = 1'b1; req_op[1] = 3'b100; req_a[1] = 32'h0000_0005; req_b[1] = 32'h0000_0007;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("midwait_accepted_in1", alu_in1[1], 32'h0000_0005);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_done[0] = 0; exp_done[1] = 0;
    chk_all_zero(1, "midwait_async");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midwait_no_rsp", 32'(rsp_valid[1]), 32'h0);
    end
    chk("midwait_req_ready", 32'(req_ready[1]), 32'h1);
`ifdef ALU_REQ_STATS_EN
    chk("midwait_ops_done", 32'(ops_done[1]), 32'h0);
`endif
    rsp_ready[1] = 1'b0;

    for (int it = 0; it < 40; it++) begin
      k  = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      if (op == 3'b100 && $urandom_range(0, 3) == 0) b = -a;
      do_op(k, op, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
